motor_mux_sequencer: RTL and testbench

Sequences ownership of the four bidirectional motor pins between the DSHOT controller and the USB-UART BLHeli passthrough bridge. It replaces a raw combinational switch on the serial/DSHOT mux register (0x0400) with a safe handover. In-flight DSHOT frames and UART bytes are drained first, then a guard interval drives the pins to the new owner's idle level, and passthrough auto-reverts to DSHOT after an inactivity timeout. It sits in `coredesign` between the mux register, `dshot` controller, passthrough bridge and motor pad logic.

---
 rtl/motor_mux_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_motor_mux_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_mux_sequencer.sv
// motor_mux_sequencer
//
// Hands the four bidirectional motor pins over between the DSHOT controller
// and the USB-UART BLHeli passthrough bridge. Any in-flight DSHOT frame or
// UART byte is drained first. A guard interval then drives all pins to the
// new owner's idle level. Passthrough falls back to DSHOT after an
// inactivity timeout.
//
// Parameters
//   CLK_FREQ_HZ        system clock frequency (used only to derive defaults)
//   GUARD_CYCLES       idle-drive interval at each handover, must be >= 1
//   PT_TIMEOUT_CYCLES  passthrough inactivity limit, 0 disables the timeout
//
// Ports
//   i_sys_clk       system clock
//   i_rst_n         asynchronous active-low reset
//   i_mux_sel       mux register level: 0 = passthrough, 1 = DSHOT requested
//   i_pt_motor      passthrough target motor index
//   i_dshot_busy    DSHOT frame being shifted out
//   i_uart_busy     bridge TX byte in progress toward the ESC
//   i_pt_activity   one-cycle pulse per byte moved by the bridge
//   o_dshot_en      DSHOT controller may start frames
//   o_pt_en         passthrough bridge owns the selected pin
//   o_pt_motor      latched passthrough motor index
//   o_force_idle    pad logic overrides all pins with o_force_level
//   o_force_level   forced level: 1 = UART idle high, 0 = DSHOT idle low
//   o_state         current state encoding for status readback
//   o_timeout_flag  sticky: the last passthrough session ended by timeout
module motor_mux_sequencer #(
    parameter int unsigned CLK_FREQ_HZ       = 72_000_000,
    parameter int unsigned GUARD_CYCLES      = CLK_FREQ_HZ / 10_000,
    parameter int unsigned PT_TIMEOUT_CYCLES = CLK_FREQ_HZ * 10
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic       i_mux_sel,
    input  logic [1:0] i_pt_motor,
    input  logic       i_dshot_busy,
    input  logic       i_uart_busy,
    input  logic       i_pt_activity,
    output logic       o_dshot_en,
    output logic       o_pt_en,
    output logic [1:0] o_pt_motor,
    output logic       o_force_idle,
    output logic       o_force_level,
    output logic [2:0] o_state,
    output logic       o_timeout_flag
);

    // One counter serves both the guard interval and the inactivity timer.
    localparam int unsigned CNT_MAX = (GUARD_CYCLES > PT_TIMEOUT_CYCLES) ?
                                      GUARD_CYCLES : PT_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] GUARD_LAST =
        CNT_W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PT_LAST =
        CNT_W'((PT_TIMEOUT_CYCLES == 0) ? 0 : PT_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic             PT_TIMEOUT_EN = (PT_TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        StDshot    = 3'd0,
        StDrainD   = 3'd1,
        StGuardPt  = 3'd2,
        StPassthru = 3'd3,
        StDrainPt  = 3'd4,
        StGuardD   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       pt_motor_q, pt_motor_d;
    logic             timeout_q, timeout_d;
    logic             motor_hop;
    logic             pt_expired;

    logic dshot_en_q, dshot_en_d;
    logic pt_en_q, pt_en_d;
    logic force_idle_q, force_idle_d;
    logic force_level_q, force_level_d;

    // Next state and next outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pt_motor_d = pt_motor_q;
        timeout_d  = timeout_q;

        cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        motor_hop  = (i_pt_motor != pt_motor_q);
        // Activity on the terminal count wins, so it masks the expiry.
        pt_expired = PT_TIMEOUT_EN && !i_pt_activity && (cnt_q == PT_LAST);

        unique case (state_q)
            StDshot: begin
                if (i_mux_sel) begin
                    timeout_d = 1'b0;
                end else if (!timeout_q) begin
                    // A timed-out session stays in DSHOT until the register is re-armed.
                    state_d = StDrainD;
                end
            end

            StDrainD: begin
                // A withdrawn request takes priority over a finished frame.
                if (i_mux_sel) begin
                    state_d = StDshot;
                end else if (!i_dshot_busy) begin
                    state_d    = StGuardPt;
                    pt_motor_d = i_pt_motor;
                end
            end

            StGuardPt: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = StPassthru;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StPassthru: begin
                if (i_pt_activity) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (pt_expired) begin
                    timeout_d = 1'b1;
                end
                if (pt_expired || i_mux_sel || motor_hop) begin
                    state_d = StDrainPt;
                end
            end

            StDrainPt: begin
                if (!i_uart_busy) begin
                    if (motor_hop && !i_mux_sel && !timeout_q) begin
                        state_d    = StGuardPt;
                        pt_motor_d = i_pt_motor;
                    end else begin
                        state_d = StGuardD;
                    end
                end
            end

            StGuardD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = StDshot;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = StDshot;
            end
        endcase

        // Every state change restarts the shared counter from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are decoded from the next state so they land in flops.
        dshot_en_d    = (state_d == StDshot);
        pt_en_d       = (state_d == StPassthru);
        force_idle_d  = (state_d == StGuardPt) || (state_d == StGuardD);
        force_level_d = (state_d == StGuardPt);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StDshot;
            cnt_q         <= '0;
            pt_motor_q    <= 2'd0;
            timeout_q     <= 1'b0;
            dshot_en_q    <= 1'b1;
            pt_en_q       <= 1'b0;
            force_idle_q  <= 1'b0;
            force_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pt_motor_q    <= pt_motor_d;
            timeout_q     <= timeout_d;
            dshot_en_q    <= dshot_en_d;
            pt_en_q       <= pt_en_d;
            force_idle_q  <= force_idle_d;
            force_level_q <= force_level_d;
        end
    end

    assign o_dshot_en     = dshot_en_q;
    assign o_pt_en        = pt_en_q;
    assign o_pt_motor     = pt_motor_q;
    assign o_force_idle   = force_idle_q;
    assign o_force_level  = force_level_q;
    assign o_state        = state_q;
    assign o_timeout_flag = timeout_q;

    // Pin ownership must never overlap.
    a_exclusive : assert property (@(posedge i_sys_clk) disable iff (!i_rst_n)
        !(o_dshot_en && o_pt_en));

    a_force_in_guard : assert property (@(posedge i_sys_clk) disable iff (!i_rst_n)
        o_force_idle |-> (o_state == 3'd2 || o_state == 3'd5));

endmodule

// File: tb/tb_motor_mux_sequencer.sv
module tb_motor_mux_sequencer;

    localparam int G = 8;
    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mux_sel = 1'b1;
    logic [1:0] pt_motor = 2'd0;
    logic       dshot_busy = 1'b0;
    logic       uart_busy = 1'b0;
    logic       pt_activity = 1'b0;

    logic       dshot_en;
    logic       pt_en;
    logic [1:0] pt_motor_out;
    logic       force_idle;
    logic       force_level;
    logic [2:0] state;
    logic       timeout_flag;

    typedef struct packed {
        logic       dshot_en;
        logic       pt_en;
        logic [1:0] motor;
        logic       force_idle;
        logic       force_level;
        logic [2:0] state;
        logic       flag;
    } outs_t;

    outs_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Reference model: phase by its specified encoding, guard as a countdown,
    // inactivity as a plain idle-cycle count.
    int m_state = 0;
    int m_left  = 0;
    int m_idle  = 0;
    int m_flag  = 0;
    int m_motor = 0;

    motor_mux_sequencer #(
        .CLK_FREQ_HZ      (72_000_000),
        .GUARD_CYCLES     (G),
        .PT_TIMEOUT_CYCLES(T)
    ) dut (
        .i_sys_clk     (clk),
        .i_rst_n       (rst_n),
        .i_mux_sel     (mux_sel),
        .i_pt_motor    (pt_motor),
        .i_dshot_busy  (dshot_busy),
        .i_uart_busy   (uart_busy),
        .i_pt_activity (pt_activity),
        .o_dshot_en    (dshot_en),
        .o_pt_en       (pt_en),
        .o_pt_motor    (pt_motor_out),
        .o_force_idle  (force_idle),
        .o_force_level (force_level),
        .o_state       (state),
        .o_timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    function automatic outs_t dut_outs();
        outs_t o;
        o = {dshot_en, pt_en, pt_motor_out, force_idle, force_level, state, timeout_flag};
        return o;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o = {(m_state == 0), (m_state == 3), 2'(m_motor),
             (m_state == 2 || m_state == 5), (m_state == 2), 3'(m_state), (m_flag != 0)};
        return o;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_idle  = 0;
        m_flag  = 0;
        m_motor = 0;
    endtask

    task automatic model_step(input int mux, input int ptm, input int db, input int ub,
                              input int act);
        int ns;
        int tmo;
        ns = m_state;
        case (m_state)
            0: begin
                if (mux != 0) m_flag = 0;
                else if (m_flag == 0) ns = 1;
            end
            1: begin
                if (mux != 0) ns = 0;
                else if (db == 0) begin
                    ns = 2;
                    m_motor = ptm;
                    m_left = G;
                end
            end
            2: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    ns = 3;
                    m_idle = 0;
                end
            end
            3: begin
                tmo = (act == 0 && m_idle == T - 1) ? 1 : 0;
                m_idle = (act != 0) ? 0 : m_idle + 1;
                if (tmo != 0) m_flag = 1;
                if (tmo != 0 || mux != 0 || ptm != m_motor) ns = 4;
            end
            4: begin
                if (ub == 0) begin
                    if (ptm != m_motor && mux == 0 && m_flag == 0) begin
                        ns = 2;
                        m_motor = ptm;
                    end else begin
                        ns = 5;
                    end
                    m_left = G;
                end
            end
            5: begin
                m_left = m_left - 1;
                if (m_left == 0) ns = 0;
            end
            default: ns = 0;
        endcase
        m_state = ns;
    endtask

    // One clock: drive inputs, let the edge happen, queue the model's answer.
    task automatic step(input int mux, input int ptm, input int db, input int ub,
                        input int act);
        mux_sel     = (mux != 0);
        pt_motor    = 2'(ptm);
        dshot_busy  = (db != 0);
        uart_busy   = (ub != 0);
        pt_activity = (act != 0);
        @(posedge clk);
        model_step(mux, ptm, db, ub, act);
        exp_q.push_back(model_outs());
        @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reset asserted between edges; outputs must change with no clock.
    task automatic do_reset();
        outs_t a;
        #1;
        #2 rst_n = 1'b0;
        #1;
        a = dut_outs();
        vectors++;
        if (a !== 10'b1000000000) begin
            miscompares++;
            $display("FAIL async_reset: got %b, expected %b", a, 10'b1000000000);
        end
        model_reset();
        mux_sel     = 1'b1;
        pt_motor    = 2'd0;
        dshot_busy  = 1'b0;
        uart_busy   = 1'b0;
        pt_activity = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enter_pt(input int m);
        repeat (G + 2) step(0, m, 0, 0, 0);
    endtask

    task automatic go_dshot();
        for (int k = 0; k < 50 && m_state != 0; k++) step(1, m_motor, 0, 0, 0);
        step(1, m_motor, 0, 0, 0);
    endtask

    // Monitor: invariants every cycle, scoreboard pop whenever a result is due.
    initial begin
        outs_t e;
        outs_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                vectors++;
                if (dshot_en && pt_en) begin
                    miscompares++;
                    $display("FAIL exclusive: got dshot_en=%b pt_en=%b, expected not both 1",
                             dshot_en, pt_en);
                end
                vectors++;
                if (force_idle && !(state == 3'd2 || state == 3'd5)) begin
                    miscompares++;
                    $display("FAIL force_in_guard: got force_idle=1 in state %0d, expected 2 or 5",
                             state);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_outs();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got en=%b pt=%b mot=%0d fi=%b fl=%b st=%0d flag=%b, expected en=%b pt=%b mot=%0d fi=%b fl=%b st=%0d flag=%b",
                             $time, a.dshot_en, a.pt_en, a.motor, a.force_idle, a.force_level,
                             a.state, a.flag, e.dshot_en, e.pt_en, e.motor, e.force_idle,
                             e.force_level, e.state, e.flag);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected $finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int r_mux;
        int r_motor;
        int r_db;
        int r_ub;
        int r_act;
        int mux_div;

        do_reset();
        repeat (3) step(1, 0, 0, 0, 0);

        // Handover with a frame in flight for 5 cycles.
        step(0, 1, 1, 0, 0);
        check("dshot_en_drop", int'(dshot_en), 0);
        cnt = (state == 3'd1) ? 1 : 0;
        repeat (4) begin
            step(0, 1, 1, 0, 0);
            if (state == 3'd1) cnt++;
        end
        check("drain_d_cycles", cnt, 5);
        cnt = 0;
        repeat (G + 1) begin
            step(0, 1, 0, 0, 0);
            if (force_idle && force_level) cnt++;
        end
        check("guard_pt_cycles", cnt, G);
        check("pt_en_after_guard", int'(pt_en), 1);
        check("pt_motor_latched", int'(pt_motor_out), 1);

        // Motor hop with a UART byte in flight for 3 cycles.
        cnt = 0;
        repeat (3) begin
            step(0, 3, 0, 1, 0);
            if (state == 3'd4) cnt++;
        end
        check("drain_pt_cycles", cnt, 3);
        cnt = 0;
        repeat (G + 1) begin
            step(0, 3, 0, 0, 0);
            if (state == 3'd2) cnt++;
        end
        check("hop_guard_cycles", cnt, G);
        check("hop_state", int'(state), 3);
        check("hop_motor", int'(pt_motor_out), 3);

        // Periodic activity keeps passthrough alive.
        for (int i = 0; i < 300; i++) step(0, 3, 0, 0, (i % 50 == 49) ? 1 : 0);
        check("alive_with_activity", int'(state), 3);
        repeat (T - 1) step(0, 3, 0, 0, 0);
        check("alive_before_limit", int'(state), 3);
        step(0, 3, 0, 0, 0);
        check("timeout_exit_state", int'(state), 4);
        check("timeout_flag_set", int'(timeout_flag), 1);
        cnt = 0;
        repeat (G + 1) begin
            step(0, 3, 0, 0, 0);
            if (force_idle && !force_level) cnt++;
        end
        check("guard_d_cycles", cnt, G);
        check("timeout_back_dshot", int'(state), 0);
        cnt = 0;
        repeat (20) begin
            step(0, 3, 0, 0, 0);
            if (state != 3'd0) cnt++;
        end
        check("stay_dshot_after_timeout", cnt, 0);
        step(1, 3, 0, 0, 0);
        check("flag_rearm", int'(timeout_flag), 0);
        step(0, 3, 0, 0, 0);
        check("handover_restart", int'(state), 1);

        // Timeout and mux request on the same edge: timeout wins.
        repeat (G + 1) step(0, 3, 0, 0, 0);
        repeat (T - 1) step(0, 3, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        check("tmo_vs_req_flag", int'(timeout_flag), 1);
        step(1, 3, 0, 0, 0);
        check("tmo_vs_req_guard_d", int'(state), 5);
        go_dshot();

        // Abort while draining DSHOT: no guard at all.
        cnt = 0;
        repeat (2) begin
            step(0, 2, 1, 0, 0);
            if (force_idle) cnt++;
        end
        repeat (4) begin
            step(1, 2, 1, 0, 0);
            if (force_idle) cnt++;
        end
        check("abort_no_guard", cnt, 0);
        check("abort_state", int'(state), 0);

        // Activity on the terminal count keeps the session.
        enter_pt(0);
        repeat (T - 1) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("activity_wins", int'(state), 3);

        // Asynchronous reset mid-passthrough.
        repeat (5) step(0, 0, 0, 0, 0);
        do_reset();
        step(1, 0, 0, 0, 0);
        check("post_reset_state", int'(state), 0);
        check("post_reset_dshot_en", int'(dshot_en), 1);

        // Randomised traffic; the second half holds requests longer to reach timeouts.
        r_mux = 1;
        r_motor = 0;
        for (int i = 0; i < 4000; i++) begin
            mux_div = (i < 2000) ? 20 : 250;
            if ($urandom_range(0, mux_div - 1) == 0) r_mux = 1 - r_mux;
            if ($urandom_range(0, 39) == 0) r_motor = int'($urandom_range(0, 3));
            r_db  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r_ub  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r_act = ($urandom_range(0, 59) == 0) ? 1 : 0;
            step(r_mux, r_motor, r_db, r_ub, r_act);
            if (i == 3000) do_reset();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
